// File: rtl/uart_pgm_loader_pkg.sv
// Shared definitions for the UART program loader: frame field widths,
// default sync marker and the loader state encoding.
package uart_pgm_loader_pkg;

    localparam int BYTE_W  = 8;
    localparam int WORD_W  = 32;
    localparam int LEN_W   = 16;
    localparam int STATE_W = 3;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_LEN0 = 3'd1;
    localparam logic [STATE_W-1:0] ST_LEN1 = 3'd2;
    localparam logic [STATE_W-1:0] ST_DATA = 3'd3;
    localparam logic [STATE_W-1:0] ST_CSUM = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE = 3'd5;
    localparam logic [STATE_W-1:0] ST_ERR  = 3'd6;

    // True while a frame is being received (LEN0 through CSUM).
    function automatic logic is_busy_state(input logic [STATE_W-1:0] st);
        case (st)
            ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM: is_busy_state = 1'b1;
            default:                            is_busy_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_pgm_loader_assembler.sv
// Little-endian byte-to-word assembler. Bytes 0..2 are parked in a staging
// register; the 4th byte completes the word, which is loaded into a holding
// register together with a one-cycle strobe. The holding register keeps the
// last complete word until the next one, so a partial word never leaks out.
module pgm_word_assembler
    import uart_pgm_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              byte_vld,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_last,
    output logic              word_stb,
    output logic [WORD_W-1:0] word
);

    logic [1:0]        byte_idx_r;
    logic [23:0]       lo_r;
    logic [WORD_W-1:0] word_r;
    logic              word_stb_r;

    // Byte index, staging of bytes 0..2 and completion of the word on byte 3
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx_r <= 2'd0;
            lo_r       <= 24'h000000;
            word_r     <= 32'h00000000;
            word_stb_r <= 1'b0;
        end else if (clr) begin
            byte_idx_r <= 2'd0;
            lo_r       <= 24'h000000;
            word_stb_r <= 1'b0;
        end else begin
            word_stb_r <= 1'b0;
            if (byte_vld) begin
                case (byte_idx_r)
                    2'd0: lo_r[7:0]   <= byte_data;
                    2'd1: lo_r[15:8]  <= byte_data;
                    2'd2: lo_r[23:16] <= byte_data;
                    default: begin
                        word_r     <= {byte_data, lo_r};
                        word_stb_r <= 1'b1;
                    end
                endcase
                byte_idx_r <= byte_idx_r + 2'd1;
            end
        end
    end

    assign word_last = (byte_idx_r == 2'd3);
    assign word_stb  = word_stb_r;
    assign word      = word_r;

endmodule

// File: rtl/uart_pgm_loader.sv
// Framed program loader: SYNC, LEN (16-bit LE), LEN words of payload and an
// 8-bit additive checksum. Payload words are written to instruction memory
// as they complete; the checksum verdict arrives afterwards, so `error`
// means the memory image is invalid and must be reloaded.
module uart_pgm_loader
    import uart_pgm_loader_pkg::*;
#(
    parameter int         ADDR_W      = 10,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              pgm_mode,
    input  logic              rx_data_ready,
    input  logic [7:0]        rx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam int               LEN_W1   = LEN_W + 1;
    localparam logic [LEN_W:0]   LEN_MAX  = LEN_W1'(2 ** ADDR_W);

    logic [STATE_W-1:0] state_r;
    logic [LEN_W-1:0]   len_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [ADDR_W-1:0]  imem_addr_r;
    logic [ADDR_W:0]    word_count_r;
    logic [7:0]         csum_r;
    logic [TMO_W-1:0]   tmo_r;
    logic               busy_r;
    logic               done_r;
    logic               error_r;

    logic               byte_v_s;
    logic               start_s;
    logic               asm_vld_s;
    logic               word_last_s;
    logic               word_stb_s;
    logic [31:0]        word_s;
    logic [LEN_W-1:0]   len_nx_s;
    logic               len_ok_s;
    logic [ADDR_W:0]    wc_next_s;
    logic               frame_end_s;

    // Qualify the incoming byte and derive frame-start, length and last-word conditions
    always_comb begin
        byte_v_s  = rx_data_ready & pgm_mode;
        start_s   = 1'b0;
        asm_vld_s = 1'b0;
        if (state_r == ST_IDLE || state_r == ST_DONE || state_r == ST_ERR) begin
            start_s = byte_v_s & (rx_data == SYNC_BYTE);
        end else if (state_r == ST_DATA) begin
            asm_vld_s = byte_v_s;
        end else begin
            start_s   = 1'b0;
        end
        len_nx_s    = {rx_data, len_r[7:0]};
        len_ok_s    = (len_nx_s != {LEN_W{1'b0}}) && ({1'b0, len_nx_s} <= LEN_MAX);
        wc_next_s   = word_count_r + {{ADDR_W{1'b0}}, 1'b1};
        frame_end_s = (LEN_W'(wc_next_s) == len_r);
    end

    pgm_word_assembler u_asm (
        .clk       (clk_100MHz),
        .reset     (reset),
        .clr       (start_s),
        .byte_vld  (asm_vld_s),
        .byte_data (rx_data),
        .word_last (word_last_s),
        .word_stb  (word_stb_s),
        .word      (word_s)
    );

    // Frame sequencing, length/address/word counters, checksum and inter-byte timeout
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            len_r        <= {LEN_W{1'b0}};
            addr_r       <= {ADDR_W{1'b0}};
            imem_addr_r  <= {ADDR_W{1'b0}};
            word_count_r <= {(ADDR_W+1){1'b0}};
            csum_r       <= 8'h00;
            tmo_r        <= {TMO_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_s) begin
                        state_r      <= ST_LEN0;
                        addr_r       <= {ADDR_W{1'b0}};
                        word_count_r <= {(ADDR_W+1){1'b0}};
                        csum_r       <= 8'h00;
                        tmo_r        <= {TMO_W{1'b0}};
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        error_r      <= 1'b0;
                    end
                end
                ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM: begin
                    if (!pgm_mode) begin
                        // abort wins over a byte arriving in the same cycle
                        state_r <= ST_ERR;
                        busy_r  <= 1'b0;
                        error_r <= 1'b1;
                    end else if (rx_data_ready) begin
                        tmo_r <= {TMO_W{1'b0}};
                        case (state_r)
                            ST_LEN0: begin
                                len_r[7:0] <= rx_data;
                                state_r    <= ST_LEN1;
                            end
                            ST_LEN1: begin
                                len_r <= len_nx_s;
                                if (len_ok_s) begin
                                    state_r <= ST_DATA;
                                end else begin
                                    state_r <= ST_ERR;
                                    busy_r  <= 1'b0;
                                    error_r <= 1'b1;
                                end
                            end
                            ST_DATA: begin
                                csum_r <= csum_r + rx_data;
                                if (word_last_s) begin
                                    imem_addr_r  <= addr_r;
                                    addr_r       <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                                    word_count_r <= wc_next_s;
                                    if (frame_end_s) begin
                                        state_r <= ST_CSUM;
                                    end
                                end
                            end
                            ST_CSUM: begin
                                busy_r <= 1'b0;
                                if (rx_data == csum_r) begin
                                    state_r <= ST_DONE;
                                    done_r  <= 1'b1;
                                end else begin
                                    state_r <= ST_ERR;
                                    error_r <= 1'b1;
                                end
                            end
                            default: begin
                                state_r <= ST_ERR;
                                busy_r  <= 1'b0;
                                error_r <= 1'b1;
                            end
                        endcase
                    end else if (tmo_r == TMO_LAST) begin
                        state_r <= ST_ERR;
                        busy_r  <= 1'b0;
                        error_r <= 1'b1;
                    end else begin
                        tmo_r <= tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_we    = word_stb_s;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = word_s;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign word_count = word_count_r;

endmodule
